// File: rtl/led_scanner.sv
// led_scanner: N-LED chaser (bounce / rotate / fill-bounce) stepped by a clock-enable tick
// derived from the single board clock, with run-time mode, speed and pause control.
module led_scanner #(
    parameter int N       = 8,
    parameter int CLK_HZ  = 50_000_000,
    parameter int STEP_HZ = 1
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    input  logic [1:0]   mode,
    input  logic [1:0]   speed,
    input  logic         pause,
    output logic [N-1:0] LEDR,
    output logic         tick,
    output logic         dir
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int CW  = $clog2(DIV);
    localparam int PW  = $clog2(N);
    localparam logic [PW-1:0] TOP = PW'(N - 1);

    logic [CW-1:0] cnt, term;
    logic [1:0]    speed_q;
    logic [PW-1:0] pos, pos_nxt, bounce_pos;
    logic          dir_nxt, bounce_dir;
    logic [N-1:0]  led_nxt;

    assign term = CW'((DIV >> speed) - 1);

    // A speed change restarts the period so no short or doubled step can occur.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt     <= '0;
            tick    <= 1'b0;
            speed_q <= 2'b00;
        end else if (pause) begin
            tick <= 1'b0;
        end else if (speed != speed_q) begin
            cnt     <= '0;
            tick    <= 1'b0;
            speed_q <= speed;
        end else if (cnt == term) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pos  <= TOP;
            dir  <= 1'b0;
            LEDR <= {1'b1, {(N-1){1'b0}}};
        end else if (tick && !pause) begin
            pos  <= pos_nxt;
            dir  <= dir_nxt;
            LEDR <= led_nxt;
        end
    end

    // End LEDs turn around immediately, so each end is lit for a single step.
    always_comb begin
        bounce_pos = dir ? ((pos == TOP) ? TOP - 1'b1 : pos + 1'b1)
                         : ((pos == '0) ? PW'(1) : pos - 1'b1);
        bounce_dir = dir ? (pos != TOP) : (pos == '0);
        pos_nxt    = (mode == 2'b01) ? ((pos == '0) ? TOP : pos - 1'b1)
                   : (mode == 2'b10) ? ((pos == TOP) ? '0 : pos + 1'b1)
                   : bounce_pos;
        dir_nxt    = (mode == 2'b01) ? 1'b0 : (mode == 2'b10) ? 1'b1 : bounce_dir;
    end

    always_comb led_nxt = (mode == 2'b11) ? {N{1'b1}} << pos_nxt : N'(1) << pos_nxt;
endmodule

// File: tb/tb_led_scanner.sv
// tb_led_scanner: directed scenarios for led_scanner (N=8, DIV=16) checked every cycle
// against a bounce-cycle-index model, plus hand-computed step sequences and timings.
module tb_led_scanner;
    localparam int N = 8;
    localparam int DIV = 16;

    logic       clk = 0, rst_n = 1, pause = 0, chk_en = 0;
    logic [1:0] mode = 0, speed = 0;
    logic [7:0] LEDR;
    logic       tick, dir;
    int         total = 0, passed = 0;

    led_scanner #(.N(N), .CLK_HZ(DIV), .STEP_HZ(1)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .mode(mode), .speed(speed), .pause(pause),
        .LEDR(LEDR), .tick(tick), .dir(dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: bounce walks a closed cycle of 2N-2 positions indexed 1..2N-2
    // (1..N-1 moving right, N..2N-2 moving left); rotations are modular arithmetic.
    int         m_el, m_pos;
    logic       m_tick, m_dir;
    logic [1:0] m_spd;
    logic [7:0] m_led;

    function automatic int bk(input int p, input logic d);
        return (d ? N - 1 + p : N - 1 - p) % (2 * N - 2) + 1;
    endfunction

    function automatic int nxt_pos(input logic [1:0] md, input int p, input logic d);
        int k = bk(p, d);
        return md == 1 ? (p + N - 1) % N : md == 2 ? (p + 1) % N : (k >= N ? k - (N - 1) : N - 1 - k);
    endfunction

    function automatic logic nxt_dir(input logic [1:0] md, input int p, input logic d);
        return md == 1 ? 1'b0 : md == 2 ? 1'b1 : (bk(p, d) >= N);
    endfunction

    function automatic logic [7:0] enc(input logic [1:0] md, input int p);
        logic [7:0] ones = 8'hFF, one = 8'h01;
        return md == 3 ? ones << p : one << p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_el <= 0; m_tick <= 0; m_spd <= 0; m_pos <= N - 1; m_dir <= 0; m_led <= 8'h80;
        end else begin
            if (pause) m_tick <= 0;
            else if (speed != m_spd) begin m_el <= 0; m_tick <= 0; m_spd <= speed; end
            else if (m_el + 1 == (DIV >> speed)) begin m_el <= 0; m_tick <= 1; end
            else begin m_el <= m_el + 1; m_tick <= 0; end
            if (m_tick && !pause) begin
                m_pos <= nxt_pos(mode, m_pos, m_dir);
                m_dir <= nxt_dir(mode, m_pos, m_dir);
                m_led <= enc(mode, nxt_pos(mode, m_pos, m_dir));
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        check("ledr_model", LEDR, m_led);
        check("tick_model", tick, m_tick);
        check("dir_model", dir, m_dir);
    end

    task automatic do_reset(input logic [1:0] md, input logic [1:0] sp);
        rst_n = 0; mode = md; speed = sp; pause = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    // Returns negedges waited until tick is seen, and LEDR one cycle later.
    task automatic next_step(output logic [7:0] led, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!tick && cyc < 100);
        if (!tick) check("tick_timeout", 0, 1);
        @(negedge clk);
        led = LEDR;
    endtask

    logic [7:0] b_led [15] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                              8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
    logic       b_dir [15] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] r_led [15] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] l_led [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] f_led [14] = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFE,
                              8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

    initial begin
        logic [7:0] led;
        int cyc, n;
        #1 rst_n = 0;
        #1 chk_en = 1;
        @(negedge clk);
        check("reset_ledr", LEDR, 8'h80);
        check("reset_tick", tick, 0);
        check("reset_dir", dir, 0);

        do_reset(2'b00, 2'b00);
        for (int i = 0; i < 15; i++) begin
            next_step(led, cyc);
            check("bounce_ledr", led, b_led[i]);
            check("bounce_dir", dir, b_dir[i]);
            if (i == 0) check("first_tick_cycles", cyc, 16);
            if (i == 1) check("tick_period", cyc, 15);
        end

        do_reset(2'b01, 2'b00);
        for (int i = 0; i < 15; i++) begin
            next_step(led, cyc);
            check("rot_right_ledr", led, r_led[i]);
        end
        mode = 2'b10;
        for (int i = 0; i < 8; i++) begin
            next_step(led, cyc);
            check("rot_left_ledr", led, l_led[i]);
            check("rot_left_dir", dir, 1);
        end

        do_reset(2'b11, 2'b00);
        for (int i = 0; i < 14; i++) begin
            next_step(led, cyc);
            check("fill_ledr", led, f_led[i]);
        end

        do_reset(2'b00, 2'b00);
        repeat (5) @(negedge clk);
        pause = 1;
        n = 0;
        repeat (40) begin @(negedge clk); if (tick) n++; end
        check("pause_ticks", n, 0);
        check("pause_ledr", LEDR, 8'h80);
        pause = 0;
        next_step(led, cyc);
        check("pause_resume_cycles", cyc, 11);
        check("pause_resume_ledr", led, 8'h40);

        do_reset(2'b00, 2'b11);
        next_step(led, cyc);
        check("fast_first_cycles", cyc, 3);
        check("fast_first_ledr", led, 8'h40);
        next_step(led, cyc);
        check("fast_period", cyc, 1);
        check("fast_second_ledr", led, 8'h20);
        speed = 2'b00;
        next_step(led, cyc);
        check("speed_change_cycles", cyc, 17);
        check("speed_change_ledr", led, 8'h10);

        do_reset(2'b00, 2'b00);
        for (int i = 0; i < 9; i++) next_step(led, cyc);
        check("pre_reset_ledr", LEDR, 8'h04);
        check("pre_reset_dir", dir, 1);
        #2 rst_n = 0;
        #1;
        check("async_reset_ledr", LEDR, 8'h80);
        check("async_reset_dir", dir, 0);
        check("async_reset_tick", tick, 0);
        @(negedge clk);
        rst_n = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (LEDR != 8'h40 && n < 100);
        check("post_reset_step_edge", n, 17);

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/led_scanner.md
# led_scanner

Parametrised LED chaser for the board LED bank, driven directly from the 50 MHz board clock. Generalises the fixed 8-LED, 1 Hz bounce to:
- N LEDs with a configurable step rate;
- run-time mode, speed and pause control;
- a single clock domain, using a clock-enable tick instead of a derived clock.

It sits between the board switches/keys and LEDR and is the standard LED pattern source for lab top levels.

## Interface
- N, 8, number of LEDs; must be ≥ 2
- CLK_HZ, 50_000_000, input clock frequency
- STEP_HZ, 1, step rate at speed 0; DIV = CLK_HZ/STEP_HZ (integer division), must satisfy DIV ≥ 8
- CLOCK_50  in  1  system clock; one clock, all state on its rising edge
- RESET_N  in  1  reset, asynchronous, active-low
- mode  in  2  pattern select: 00 bounce, 01 rotate right, 10 rotate left, 11 fill-bounce
- speed  in  2  step period = DIV >> speed cycles (×1, ×2, ×4, ×8 rate)
- pause  in  1  1 = freeze the pattern and the tick counter
- LEDR  out  N  LED pattern, registered; bit N-1 is the leftmost LED
- tick  out  1  registered one-cycle pulse marking each step
- dir  out  1  current direction: 0 = moving right (toward bit 0), 1 = moving left

## Operation
- **State:** cnt (width $clog2(DIV)), pos (0..N-1), dir, speed_q, plus the LEDR and tick registers.
- **Reset values:** cnt=0, pos=N-1, dir=0, speed_q=0, tick=0, LEDR has only bit N-1 set (0x80 for N=8) regardless of mode.
- **Tick generator:**
  - TERM = (DIV >> speed) − 1.
  - If pause=1: cnt holds and tick=0.
  - Else if speed ≠ speed_q: cnt←0, tick=0 and speed_q←speed. A speed change never produces a short or double step.
  - Else if cnt == TERM: cnt←0 and tick←1.
  - Else: cnt←cnt+1 and tick←0.
- **Step:** on each clock edge where tick=1, pos/dir update according to mode. mode is sampled only at that edge.
  - 00 bounce:
    - dir=0: if pos==0 then pos←1, dir←1; else pos←pos−1.
    - dir=1: if pos==N-1 then pos←N-2, dir←0; else pos←pos+1.
    - Each end LED is lit for exactly one step; there is no double dwell.
  - 01 rotate right: pos←(pos==0) ? N-1 : pos−1; dir←0.
  - 10 rotate left: pos←(pos==N-1) ? 0 : pos+1; dir←1.
  - 11 fill-bounce: pos/dir follow the bounce rules.
- **LEDR encoding:** LEDR is registered from the next pos and the sampled mode.
  - Modes 00/01/10: one-hot at pos.
  - Mode 11: bits N-1 down to pos set, i.e. a bar growing from the left.
- **Mode change:** takes effect at the next tick. pos is retained; dir is retained for 00/11 and forced as listed for 01/10. LEDR keeps its old encoding until that tick.
- **pause:** LEDR, pos and dir hold. Releasing pause resumes the count from the held cnt value.
- **Reset mid-operation:** RESET_N low immediately and asynchronously forces the reset values. Operation resumes from the reset state on the first edge after deassertion.

## Timing
- tick is high for exactly 1 cycle. Without pause or speed change, the tick period is DIV >> speed cycles.
- The first tick after reset occurs at cycle DIV >> speed after the first active edge, counting from cnt=0.
- LEDR, pos and dir change on the edge that ends the tick-high cycle. The new pattern is visible 1 cycle after tick rises.
- No combinational path from inputs to outputs.
- No logic other than CLOCK_50 may be used as a clock.

## Test plan
Parameters for all scenarios: N=8, CLK_HZ=16, STEP_HZ=1 (DIV=16).
- **Bounce:** reset, mode=00, speed=0 → tick every 16 cycles. LEDR steps 80,40,20,10,08,04,02,01,02,04,08,10,20,40,80,40. dir goes 0→1 on the step to 02 and 1→0 on the step to 40.
- **Rotation:** rotate right (mode=01) from reset → 80,40,…,01,80. Switch to mode=10 while at 01 → next tick 02 with dir=1; wraps 80→01.
- **Fill-bounce:** mode=11 from reset → 80,C0,E0,F0,F8,FC,FE,FF,FE,FC,…,C0,80.
- **Pause:** assert pause for 40 cycles with cnt=5 → LEDR/tick frozen, no ticks. On release, the next tick arrives 11 cycles later.
- **Speed change:** speed=3 → ticks every 2 cycles. Change speed 3→0 mid-count → cnt clears, no tick that cycle, next tick 16 cycles later.
- **Async reset:** drop RESET_N between clock edges mid-bounce (LEDR=04, dir=1) → LEDR=80, dir=0, tick=0 without waiting for a clock edge. After release, the first step to 40 occurs 17 cycles after the first edge.
